// File: rtl/gelato_types.sv
// Shared types for the Gelato fetch path: warp/split identifiers, address and
// instruction words, and the fetch-unit state encoding.
package gelato_types;

   localparam int WARP_NUM_WIDTH        = 5;
   localparam int SPLIT_TABLE_NUM_WIDTH = 3;

   typedef logic [WARP_NUM_WIDTH-1:0]        warp_num_t;
   typedef logic [SPLIT_TABLE_NUM_WIDTH-1:0] split_table_num_t;
   typedef logic [31:0]                      addr_t;
   typedef logic [31:0]                      inst_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      OUT,
      DRAIN
   } ifetch_state_t;

   // Instructions are word aligned; any set low bit is a fetch fault.
   function automatic logic misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/gelato_fetchskd_ifetch_if.sv
// Fetch-scheduler to fetch-unit PC hand-off: the scheduler offers a warp PC
// with valid and the fetch unit acknowledges it with a one-cycle caught pulse.
interface gelato_fetchskd_ifetch_if
   import gelato_types::*;
#(
   parameter int ADDR_WIDTH = 32
);

   logic                  valid;
   logic [ADDR_WIDTH-1:0] pc;
   warp_num_t             warp_num;
   split_table_num_t      split_table_num;
   logic                  caught;

   modport master (
      output valid,
      output pc,
      output warp_num,
      output split_table_num,
      input  caught
   );

   modport slave (
      input  valid,
      input  pc,
      input  warp_num,
      input  split_table_num,
      output caught
   );

endinterface

// File: rtl/gelato_ifetch.sv
// Instruction fetch unit: takes one warp PC at a time, reads the word from the
// instruction cache and holds it, tagged, in an output register for the decoder.
module gelato_ifetch
   import gelato_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rdy,

   gelato_fetchskd_ifetch_if.slave        inst_pc,

   output logic                           icache_req_valid,
   output logic [ADDR_WIDTH-1:0]          icache_req_addr,
   input  logic                           icache_req_ready,
   input  logic                           icache_resp_valid,
   input  logic [INST_WIDTH-1:0]          icache_resp_data,

   input  logic                           flush,

   output logic                           dec_valid,
   input  logic                           dec_ready,
   output logic [ADDR_WIDTH-1:0]          dec_pc,
   output warp_num_t                      dec_warp_num,
   output split_table_num_t               dec_split_table_num,
   output logic [INST_WIDTH-1:0]          dec_inst,
   output logic                           dec_fault
);

   ifetch_state_t state;

   // NOTE: state and every output live in this one clocked block and use <=,
   // so each branch reads the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= IDLE;
         inst_pc.caught      <= 1'b0;
         icache_req_valid    <= 1'b0;
         icache_req_addr     <= '0;
         dec_valid           <= 1'b0;
         dec_fault           <= 1'b0;
         dec_inst            <= '0;
         dec_pc              <= '0;
         dec_warp_num        <= '0;
         dec_split_table_num <= '0;
      end else if (rdy) begin
         inst_pc.caught <= 1'b0;

         if (flush) begin
            case (state)
               REQ: begin
                  icache_req_valid <= 1'b0;
                  // A request the cache took on this edge still owes a response.
                  state            <= icache_req_ready ? DRAIN : IDLE;
               end
               WAIT:  state <= icache_resp_valid ? IDLE : DRAIN;
               OUT: begin
                  dec_valid <= 1'b0;
                  state     <= IDLE;
               end
               // The owed response retires the drain even under flush, or the
               // unit would never leave DRAIN.
               DRAIN: if (icache_resp_valid) state <= IDLE;
               default: state <= IDLE;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  if (inst_pc.valid && !inst_pc.caught) begin
                     inst_pc.caught      <= 1'b1;
                     dec_pc              <= inst_pc.pc;
                     dec_warp_num        <= inst_pc.warp_num;
                     dec_split_table_num <= inst_pc.split_table_num;
                     if (misaligned(inst_pc.pc[1:0])) begin
                        dec_fault <= 1'b1;
                        dec_inst  <= '0;
                        dec_valid <= 1'b1;
                        state     <= OUT;
                     end else begin
                        icache_req_addr  <= inst_pc.pc;
                        icache_req_valid <= 1'b1;
                        state            <= REQ;
                     end
                  end
               end
               REQ: begin
                  if (icache_req_ready) begin
                     icache_req_valid <= 1'b0;
                     state            <= WAIT;
                  end
               end
               WAIT: begin
                  if (icache_resp_valid) begin
                     dec_inst  <= icache_resp_data;
                     dec_fault <= 1'b0;
                     dec_valid <= 1'b1;
                     state     <= OUT;
                  end
               end
               OUT: begin
                  if (dec_ready) begin
                     dec_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
               DRAIN: if (icache_resp_valid) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gelato_ifetch.sv
// Bench for gelato_ifetch: directed cycle table, hand-written flush/freeze/reset
// sequences, then randomized traffic against a transaction-level model.
module tb_gelato_ifetch;
   import gelato_types::*;

   localparam int AW = 32;
   localparam int IW = 32;

   logic             clk               = 1'b0;
   logic             rst_n             = 1'b0;
   logic             rdy               = 1'b0;
   logic             flush             = 1'b0;
   logic             icache_req_ready  = 1'b0;
   logic             icache_resp_valid = 1'b0;
   logic [IW-1:0]    icache_resp_data  = '0;
   logic             dec_ready         = 1'b0;
   logic             icache_req_valid;
   logic [AW-1:0]    icache_req_addr;
   logic             dec_valid;
   logic [AW-1:0]    dec_pc;
   warp_num_t        dec_warp_num;
   split_table_num_t dec_split_table_num;
   logic [IW-1:0]    dec_inst;
   logic             dec_fault;

   gelato_fetchskd_ifetch_if #(.ADDR_WIDTH(AW)) inst_pc_if ();

   gelato_ifetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .rdy                 (rdy),
      .inst_pc             (inst_pc_if),
      .icache_req_valid    (icache_req_valid),
      .icache_req_addr     (icache_req_addr),
      .icache_req_ready    (icache_req_ready),
      .icache_resp_valid   (icache_resp_valid),
      .icache_resp_data    (icache_resp_data),
      .flush               (flush),
      .dec_valid           (dec_valid),
      .dec_ready           (dec_ready),
      .dec_pc              (dec_pc),
      .dec_warp_num        (dec_warp_num),
      .dec_split_table_num (dec_split_table_num),
      .dec_inst            (dec_inst),
      .dec_fault           (dec_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             caught;
      logic             req_valid;
      logic [31:0]      req_addr;
      logic             dec_valid;
      logic             dec_fault;
      logic [31:0]      dec_inst;
      logic [31:0]      dec_pc;
      warp_num_t        warp;
      split_table_num_t split;
   } obs_t;

   typedef struct {
      logic             valid;
      logic [31:0]      pc;
      warp_num_t        warp;
      split_table_num_t split;
      logic             req_ready;
      logic             resp_valid;
      logic [31:0]      resp_data;
      logic             dec_ready;
      obs_t             exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   function automatic obs_t o(logic c, logic rv, logic [31:0] ra, logic dv, logic df,
                              logic [31:0] di, logic [31:0] dp, warp_num_t w,
                              split_table_num_t s);
      obs_t r;
      r = '{caught: c, req_valid: rv, req_addr: ra, dec_valid: dv, dec_fault: df,
            dec_inst: di, dec_pc: dp, warp: w, split: s};
      return r;
   endfunction

   function automatic vec_t v(logic vl, logic [31:0] pc, warp_num_t w, split_table_num_t s,
                              logic rr, logic rv, logic [31:0] rd, logic dr, obs_t e);
      vec_t r;
      r = '{valid: vl, pc: pc, warp: w, split: s, req_ready: rr, resp_valid: rv,
            resp_data: rd, dec_ready: dr, exp: e};
      return r;
   endfunction

   // Fields without meaning in the current cycle are excluded from comparison.
   function automatic obs_t msk(obs_t x, obs_t e);
      if (!e.req_valid) x.req_addr = '0;
      if (!e.dec_valid) begin
         x.dec_fault = 1'b0;
         x.dec_inst  = '0;
         x.dec_pc    = '0;
         x.warp      = '0;
         x.split     = '0;
      end
      return x;
   endfunction

   function automatic obs_t sample();
      return o(inst_pc_if.caught, icache_req_valid, icache_req_addr, dec_valid, dec_fault,
               dec_inst, dec_pc, dec_warp_num, dec_split_table_num);
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got c=%0b rv=%0b ra=%h dv=%0b df=%0b di=%h pc=%h w=%0d s=%0d; expected c=%0b rv=%0b ra=%h dv=%0b df=%0b di=%h pc=%h w=%0d s=%0d",
                  name, act.caught, act.req_valid, act.req_addr, act.dec_valid, act.dec_fault,
                  act.dec_inst, act.dec_pc, act.warp, act.split,
                  exp.caught, exp.req_valid, exp.req_addr, exp.dec_valid, exp.dec_fault,
                  exp.dec_inst, exp.dec_pc, exp.warp, exp.split);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic apply(input logic vl, input logic [31:0] pc, input warp_num_t w,
                        input split_table_num_t s, input logic rr, input logic rv,
                        input logic [31:0] rd, input logic dr,
                        input logic fl = 1'b0, input logic en = 1'b1);
      inst_pc_if.valid           = vl;
      inst_pc_if.pc              = pc;
      inst_pc_if.warp_num        = w;
      inst_pc_if.split_table_num = s;
      icache_req_ready           = rr;
      icache_resp_valid          = rv;
      icache_resp_data           = rd;
      dec_ready                  = dr;
      flush                      = fl;
      rdy                        = en;
   endtask

   task automatic step(input string name, input obs_t e);
      @(posedge clk);
      #1;
      check(name, msk(sample(), e), msk(e, e));
   endtask

   task automatic reset_check(input string name);
      rst_n = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check(name, sample(), o(0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
   endtask

   // Transaction-level reference: one fetch in flight plus a count of cache
   // responses still owed for requests that were abandoned by flush.
   bit               m_busy, m_fault, m_req_done, m_have, m_caught;
   logic [31:0]      m_pc, m_inst;
   warp_num_t        m_warp;
   split_table_num_t m_split;
   int               owed;
   bit               hs_m, acc, hs_cache;
   bit               c_pend, hold_once, ack_seen;
   int               c_cnt;
   logic             obs_req_v;
   logic [31:0]      npc;

   function automatic obs_t model_obs();
      return o(m_caught, m_busy && !m_fault && !m_req_done, m_pc,
               m_busy && (m_fault || m_have), m_fault, m_fault ? 32'h0 : m_inst,
               m_pc, m_warp, m_split);
   endfunction

   vec_t tbl[17];
   obs_t z;

   initial begin
      z = o(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = v(1, 'h100, 3, 1, 0, 0, 0, 1, o(1, 1, 'h100, 0, 0, 0, 0, 0, 0));
      tbl[1]  = v(1, 'h100, 3, 1, 1, 0, 0, 1, z);
      tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 1, z);
      tbl[3]  = v(0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, o(0, 0, 0, 1, 0, 'hDEADBEEF, 'h100, 3, 1));
      for (int i = 4; i <= 8; i++)
         tbl[i] = v(1, 'h204, 5, 2, 0, 0, 0, 0, o(0, 0, 0, 1, 0, 'hDEADBEEF, 'h100, 3, 1));
      tbl[9]  = v(1, 'h204, 5, 2, 0, 0, 0, 1, z);
      tbl[10] = v(1, 'h204, 5, 2, 0, 0, 0, 1, o(1, 1, 'h204, 0, 0, 0, 0, 0, 0));
      tbl[11] = v(0, 0, 0, 0, 1, 0, 0, 1, z);
      tbl[12] = v(0, 0, 0, 0, 0, 1, 'hCAFEF00D, 1, o(0, 0, 0, 1, 0, 'hCAFEF00D, 'h204, 5, 2));
      tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 1, z);
      tbl[14] = v(1, 'h102, 7, 0, 0, 0, 0, 0, o(1, 0, 0, 1, 1, 0, 'h102, 7, 0));
      tbl[15] = v(1, 'h102, 7, 0, 0, 0, 0, 1, z);
      tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, z);

      reset_check("reset_state");

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].valid, tbl[i].pc, tbl[i].warp, tbl[i].split, tbl[i].req_ready,
               tbl[i].resp_valid, tbl[i].resp_data, tbl[i].dec_ready);
         step($sformatf("table_row%0d", i), tbl[i].exp);
      end

      // Flush in WAIT, scheduler offers 0x200 while the owed response drains.
      apply(1, 'h300, 1, 1, 0, 0, 0, 0);        step("fw_accept", o(1, 1, 'h300, 0, 0, 0, 0, 0, 0));
      apply(0, 0, 0, 0, 1, 0, 0, 0);            step("fw_to_wait", z);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);         step("fw_flush", z);
      for (int i = 0; i < 3; i++) begin
         apply(1, 'h200, 2, 3, 0, 0, 0, 0);     step($sformatf("fw_drain_hold%0d", i), z);
      end
      apply(1, 'h200, 2, 3, 0, 1, 'h1234, 0);   step("fw_drain_resp", z);
      check_bit("fw_resp_not_forwarded", dec_inst != 32'h1234, 1'b1);
      apply(1, 'h200, 2, 3, 0, 0, 0, 0);        step("fw_accept_after_drain", o(1, 1, 'h200, 0, 0, 0, 0, 0, 0));
      apply(0, 0, 0, 0, 1, 0, 0, 0);            step("fw_req_hs", z);
      apply(0, 0, 0, 0, 0, 1, 'h5555AAAA, 0);   step("fw_out", o(0, 0, 0, 1, 0, 'h5555AAAA, 'h200, 2, 3));
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);         step("flush_in_out", z);
      apply(1, 'h600, 0, 0, 0, 0, 0, 0);        step("fr_accept", o(1, 1, 'h600, 0, 0, 0, 0, 0, 0));
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);         step("flush_in_req", z);
      apply(0, 0, 0, 0, 1, 0, 0, 0);            step("fr_no_request", z);
      apply(1, 'h604, 0, 0, 0, 0, 0, 0);        step("fr_reaccept", o(1, 1, 'h604, 0, 0, 0, 0, 0, 0));
      apply(0, 0, 0, 0, 1, 0, 0, 0);            step("fr_req_hs", z);
      apply(0, 0, 0, 0, 0, 1, 'h77, 1);         step("fr_out", o(0, 0, 0, 1, 0, 'h77, 'h604, 0, 0));
      apply(0, 0, 0, 0, 0, 0, 0, 1);            step("fr_done", z);

      // Freeze in REQ, then reset mid-WAIT with a late response.
      apply(1, 'h400, 4, 2, 0, 0, 0, 0);        step("fz_accept", o(1, 1, 'h400, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);   step($sformatf("fz_frozen%0d", i), o(1, 1, 'h400, 0, 0, 0, 0, 0, 0));
      end
      apply(0, 0, 0, 0, 1, 0, 0, 1);            step("fz_to_wait", z);
      reset_check("reset_mid_wait");
      apply(0, 0, 0, 0, 0, 1, 'h9999, 0);       step("late_resp_ignored", z);
      apply(1, 'h500, 1, 1, 0, 0, 0, 0);        step("post_reset_accept", o(1, 1, 'h500, 0, 0, 0, 0, 0, 0));
      apply(0, 0, 0, 0, 1, 0, 0, 0);            step("pr_req_hs", z);
      apply(0, 0, 0, 0, 0, 1, 'hABCD, 1);       step("pr_out", o(0, 0, 0, 1, 0, 'hABCD, 'h500, 1, 1));
      apply(0, 0, 0, 0, 0, 0, 0, 1);            step("pr_done", z);

      // Randomized traffic against the reference model.
      reset_check("reset_before_random");
      {m_busy, m_fault, m_req_done, m_have, m_caught} = '0;
      m_pc = '0; m_inst = '0; m_warp = '0; m_split = '0; owed = 0;
      c_pend = 0; c_cnt = 0; hold_once = 0; ack_seen = 0; obs_req_v = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rdy              = ($urandom_range(0, 9) != 0);
         flush            = ($urandom_range(0, 29) == 0);
         dec_ready        = ($urandom_range(0, 3) != 0);
         icache_req_ready = ($urandom_range(0, 2) != 0);
         if (hold_once) begin
            inst_pc_if.valid = 1'b0;
            hold_once        = 0;
         end else if (m_caught && !ack_seen) begin
            ack_seen = 1;
            if ($urandom_range(0, 1) == 1) hold_once = 1;
            else inst_pc_if.valid = 1'b0;
         end else if (!inst_pc_if.valid && $urandom_range(0, 2) == 0) begin
            npc = $urandom_range(0, 'hFFFF) & 32'hFFFC;
            if ($urandom_range(0, 5) == 0) npc[1:0] = 2'($urandom_range(1, 3));
            inst_pc_if.valid           = 1'b1;
            inst_pc_if.pc              = npc;
            inst_pc_if.warp_num        = warp_num_t'($urandom);
            inst_pc_if.split_table_num = split_table_num_t'($urandom);
         end
         if (!m_caught) ack_seen = 0;
         icache_resp_valid = 1'b0;
         if (c_pend && rdy && c_cnt == 0) begin
            icache_resp_valid = 1'b1;
            icache_resp_data  = $urandom;
            c_pend            = 0;
         end else if (c_pend && c_cnt > 0) begin
            c_cnt--;
         end

         @(posedge clk);
         if (rdy) begin
            hs_cache = obs_req_v && icache_req_ready;
            hs_m     = m_busy && !m_fault && !m_req_done && icache_req_ready;
            acc      = !flush && inst_pc_if.valid && !m_caught && !m_busy && owed == 0;
            if (flush) begin
               m_busy = 0;
            end else if (m_busy) begin
               if (m_fault || m_have) begin
                  if (dec_ready) m_busy = 0;
               end else if (!m_req_done) begin
                  if (icache_req_ready) m_req_done = 1;
               end else if (icache_resp_valid) begin
                  m_have = 1;
                  m_inst = icache_resp_data;
               end
            end
            owed     = owed + int'(hs_m) - int'(icache_resp_valid);
            m_caught = acc;
            if (acc) begin
               m_busy     = 1;
               m_pc       = inst_pc_if.pc;
               m_warp     = inst_pc_if.warp_num;
               m_split    = inst_pc_if.split_table_num;
               m_fault    = (inst_pc_if.pc[1:0] != 2'b00);
               m_req_done = 0;
               m_have     = 0;
            end
            if (hs_cache) begin
               c_pend = 1;
               c_cnt  = $urandom_range(0, 2);
            end
         end
         #1;
         check($sformatf("random_cyc%0d", cyc), msk(sample(), model_obs()), msk(model_obs(), model_obs()));
         obs_req_v = icache_req_valid;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary line");
      $fatal(1);
   end

endmodule
